mem_port_arbiter: RTL

- Shares the single SLC-3 memory port between two requesters: requester 0 (CPU fetch/data path) and requester 1 (I/O or program-loader path).
- Drives the select line of the 16-bit 2:1 source multiplexer that feeds the memory address and data bus.
- Sequences each fixed-latency memory access.
- Returns read data and a one-cycle acknowledge to the winning requester.

---
 rtl/mem_port_arbiter_if.sv | 40 ++++
 rtl/mem_port_arbiter.sv | 111 +++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_if
// Description : Requester/memory bundle for the two-way memory port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              ack0;
    logic              ack1;
    logic [DATA_W-1:0] rdata;
    logic              sel;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    modport slave (
        input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_rdata,
        output ack0, ack1, rdata, sel, mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_rdata,
        input  ack0, ack1, rdata, sel, mem_en, mem_we, mem_addr, mem_wdata, busy
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Round-robin arbiter sequencing fixed-latency accesses on a
//               single memory port shared by two requesters.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int MEM_LATENCY = 2
) (
    input  wire                 clk,
    input  wire                 reset_n,
    mem_port_arbiter_if.slave   bus
);

    localparam logic [3:0] c_LAST = 4'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t            r_state;
    logic [3:0]        r_cnt;
    logic              r_last_grant;
    logic              r_sel;
    logic              r_ack0;
    logic              r_ack1;
    logic              r_busy;
    logic              r_mem_en;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_rdata;

    logic              w_grant_valid;
    logic              w_grant_idx;

    // Under contention the side that did not win last time goes first.
    assign w_grant_valid = bus.req0 | bus.req1;
    assign w_grant_idx   = (bus.req0 & bus.req1) ? ~r_last_grant : bus.req1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= 4'd0;
            r_last_grant <= 1'b1;
            r_sel        <= 1'b0;
            r_ack0       <= 1'b0;
            r_ack1       <= 1'b0;
            r_busy       <= 1'b0;
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_rdata      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_valid) begin
                        r_sel        <= w_grant_idx;
                        r_last_grant <= w_grant_idx;
                        r_mem_addr   <= w_grant_idx ? bus.addr1  : bus.addr0;
                        r_mem_wdata  <= w_grant_idx ? bus.wdata1 : bus.wdata0;
                        r_mem_we     <= w_grant_idx ? bus.we1    : bus.we0;
                        r_mem_en     <= 1'b1;
                        r_busy       <= 1'b1;
                        r_cnt        <= 4'd0;
                        r_state      <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (r_cnt == c_LAST) begin
                        r_rdata  <= bus.mem_rdata;
                        r_mem_en <= 1'b0;
                        r_mem_we <= 1'b0;
                        r_ack0   <= ~r_sel;
                        r_ack1   <= r_sel;
                        r_state  <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_DONE: begin
                    r_ack0  <= 1'b0;
                    r_ack1  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.ack0      = r_ack0;
    assign bus.ack1      = r_ack1;
    assign bus.rdata     = r_rdata;
    assign bus.sel       = r_sel;
    assign bus.mem_en    = r_mem_en;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.busy      = r_busy;

endmodule
`default_nettype wire
